// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the execute stage: the 4-bit ALU function codes,
// the 3-bit operation classes issued by the control unit, and the R-type
// funct values recognised by the ALU decoder.
// Optional feature macro: ALU_NOR_EN (consumed by alu_ctrl, not here).
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        FUNC_AND     = 4'b0000,
        FUNC_OR      = 4'b0001,
        FUNC_ADD     = 4'b0010,
        FUNC_SUB     = 4'b0110,
        FUNC_SLT     = 4'b0111,
        FUNC_NOR     = 4'b1100,
        FUNC_ILLEGAL = 4'b1111
    } alu_func_e;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_NOR   = 3'b110;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if
// Bundles the execute-stage operand/control inputs and result outputs.
//   master: the upstream stage (drives operands/controls, observes results)
//   slave : alu_exec_unit (consumes operands/controls, drives results)
// Signals:
//   in_valid, alu_op[2:0], funct[5:0], op1[31:0], op2[31:0],
//   mem_to_reg, mem_data[31:0]                      -> toward the ALU
//   alu_func[3:0], alu_result[31:0], zf, out_valid,
//   wb_data[31:0]                                   <- from the ALU
// ---------------------------------------------------------------------------
interface alu_if;
    logic        in_valid;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        mem_to_reg;
    logic [31:0] mem_data;
    logic [3:0]  alu_func;
    logic [31:0] alu_result;
    logic        zf;
    logic        out_valid;
    logic [31:0] wb_data;

    modport master (
        output in_valid, alu_op, funct, op1, op2, mem_to_reg, mem_data,
        input  alu_func, alu_result, zf, out_valid, wb_data
    );

    modport slave (
        input  in_valid, alu_op, funct, op1, op2, mem_to_reg, mem_data,
        output alu_func, alu_result, zf, out_valid, wb_data
    );
endinterface

// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl
// Combinational decoder from the control unit's operation class plus the
// instruction funct field to the 4-bit ALU function.
// Ports:
//   alu_op   in  3  operation class
//   funct    in  6  instruction bits [5:0]
//   alu_func out 4  decoded function (FUNC_ILLEGAL for unknown encodings)
// Macro ALU_NOR_EN: when defined, funct 0x27 and alu_op 110 decode to NOR;
// otherwise both decode to FUNC_ILLEGAL.
// ---------------------------------------------------------------------------
module alu_ctrl
    import alu_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    output alu_func_e  alu_func
);

    // R-type instructions carry their operation in funct; everything else
    // is fixed by the class the control unit issued.
    always_comb begin
        alu_func = FUNC_ILLEGAL;
        case (alu_op)
            OP_ADD: alu_func = FUNC_ADD;
            OP_SUB: alu_func = FUNC_SUB;
            OP_AND: alu_func = FUNC_AND;
            OP_OR:  alu_func = FUNC_OR;
            OP_SLT: alu_func = FUNC_SLT;
`ifdef ALU_NOR_EN
            OP_NOR: alu_func = FUNC_NOR;
`endif
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_func = FUNC_ADD;
                    FUNCT_SUB: alu_func = FUNC_SUB;
                    FUNCT_AND: alu_func = FUNC_AND;
                    FUNCT_OR:  alu_func = FUNC_OR;
                    FUNCT_SLT: alu_func = FUNC_SLT;
`ifdef ALU_NOR_EN
                    FUNCT_NOR: alu_func = FUNC_NOR;
`endif
                    default:   alu_func = FUNC_ILLEGAL;
                endcase
            end
            default: alu_func = FUNC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute stage of the single-cycle R-type datapath: decodes the ALU
// function, computes a 32-bit result and zero flag, registers them with a
// one-cycle latency, and selects the write-back word.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset
//   bus    alu_if.slave  operands/controls in, alu_func/alu_result/zf/
//                        out_valid/wb_data out
// Macro ALU_NOR_EN: enables NOR decoding inside alu_ctrl.
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    alu_func_e   alu_func;
    logic [31:0] result_d;
    logic [31:0] alu_result_q;
    logic        zf_q;
    logic        out_valid_q;
    logic        mem_to_reg_q;

    alu_ctrl u_alu_ctrl (
        .alu_op   (bus.alu_op),
        .funct    (bus.funct),
        .alu_func (alu_func)
    );

    // Illegal encodings fall through to the default and produce zero, which
    // in turn raises the zero flag.
    always_comb begin
        result_d = 32'd0;
        case (alu_func)
            FUNC_AND: result_d = bus.op1 & bus.op2;
            FUNC_OR:  result_d = bus.op1 | bus.op2;
            FUNC_ADD: result_d = bus.op1 + bus.op2;
            FUNC_SUB: result_d = bus.op1 - bus.op2;
            FUNC_SLT: result_d = ($signed(bus.op1) < $signed(bus.op2)) ? 32'd1 : 32'd0;
            FUNC_NOR: result_d = ~(bus.op1 | bus.op2);
            default:  result_d = 32'd0;
        endcase
    end

    // Result registers only load on valid cycles so the last result stays
    // visible across bubbles; out_valid simply tracks in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_result_q <= 32'd0;
            zf_q         <= 1'b1;
            out_valid_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                alu_result_q <= result_d;
                zf_q         <= (result_d == 32'd0);
                mem_to_reg_q <= bus.mem_to_reg;
            end
        end
    end

    // The RAM is addressed by the registered result, so its read data arrives
    // in the same cycle and is muxed in without another register stage.
    assign bus.wb_data    = mem_to_reg_q ? bus.mem_data : alu_result_q;
    assign bus.alu_func   = alu_func;
    assign bus.alu_result = alu_result_q;
    assign bus.zf         = zf_q;
    assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit. A driver issues directed and random
// operations on falling edges and pushes the expected registered outputs of
// each coming rising edge into a queue; a monitor pops one entry per cycle
// and compares. Honors ALU_NOR_EN in the reference model.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic clk;
    logic rst_n;

    alu_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] res;
        logic        zf;
        logic        mtr;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] held_res;
    logic        held_zf;
    logic        held_mtr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference: name the operation from the decode table, then do the math.
    function automatic void ref_model(input logic [2:0] op, input logic [5:0] fn,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [3:0] f, output logic [31:0] r);
        string kind;
        kind = "ill";
        case (op)
            3'd0: kind = "add";
            3'd1: kind = "sub";
            3'd3: kind = "and";
            3'd4: kind = "or";
            3'd5: kind = "slt";
`ifdef ALU_NOR_EN
            3'd6: kind = "nor";
`endif
            3'd2: begin
                if (fn == 6'h20)      kind = "add";
                else if (fn == 6'h22) kind = "sub";
                else if (fn == 6'h24) kind = "and";
                else if (fn == 6'h25) kind = "or";
                else if (fn == 6'h2A) kind = "slt";
`ifdef ALU_NOR_EN
                else if (fn == 6'h27) kind = "nor";
`endif
            end
            default: kind = "ill";
        endcase
        f = 4'b1111;
        r = 32'd0;
        if (kind == "add") begin f = 4'b0010; r = a + b; end
        else if (kind == "sub") begin f = 4'b0110; r = a + (~b + 32'd1); end
        else if (kind == "and") begin f = 4'b0000; r = a & b; end
        else if (kind == "or")  begin f = 4'b0001; r = a | b; end
        else if (kind == "nor") begin f = 4'b1100; r = ~a & ~b; end
        else if (kind == "slt") begin
            f = 4'b0111;
            if (a[31] != b[31]) r = {31'd0, a[31]};
            else                r = (a < b) ? 32'd1 : 32'd0;
        end
    endfunction

    // Drive one cycle of stimulus and queue what the next rising edge yields.
    task automatic applyStimulus(input logic rst_val, input logic vld,
                                 input logic [2:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic mtr, input logic [31:0] md);
        exp_t e;
        logic [3:0]  f;
        logic [31:0] r;
        @(negedge clk);
        rst_n          = rst_val;
        bus.in_valid   = vld;
        bus.alu_op     = op;
        bus.funct      = fn;
        bus.op1        = a;
        bus.op2        = b;
        bus.mem_to_reg = mtr;
        bus.mem_data   = md;
        ref_model(op, fn, a, b, f, r);
        if (!rst_val) begin
            held_res = 32'd0;
            held_zf  = 1'b1;
            held_mtr = 1'b0;
        end else if (vld) begin
            held_res = r;
            held_zf  = (r == 32'd0);
            held_mtr = mtr;
        end
        e.valid = rst_val & vld;
        e.res   = held_res;
        e.zf    = held_zf;
        e.mtr   = held_mtr;
        exp_q.push_back(e);
        #1;
        checkOutput("alu_func", {28'd0, bus.alu_func}, {28'd0, f});
    endtask

    // Monitor: one expected entry per rising edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, e.valid});
                checkOutput("alu_result", bus.alu_result, e.res);
                checkOutput("zf", {31'd0, bus.zf}, {31'd0, e.zf});
                checkOutput("wb_data", bus.wb_data, e.mtr ? bus.mem_data : e.res);
            end
        end
    end

    initial begin
        logic [5:0]  fn_list [6];
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        fn_list[0] = 6'h20; fn_list[1] = 6'h22; fn_list[2] = 6'h24;
        fn_list[3] = 6'h25; fn_list[4] = 6'h2A; fn_list[5] = 6'h27;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.alu_op     = 3'd0;
        bus.funct      = 6'd0;
        bus.op1        = 32'd0;
        bus.op2        = 32'd0;
        bus.mem_to_reg = 1'b0;
        bus.mem_data   = 32'h0BAD_F00D;

        // Reset held for two cycles, with garbage valid input to be ignored.
        applyStimulus(1'b0, 1'b1, 3'd0, 6'h00, 32'd1, 32'd1, 1'b1, 32'h0BAD_F00D);
        applyStimulus(1'b0, 1'b0, 3'd0, 6'h00, 32'd0, 32'd0, 1'b0, 32'h0BAD_F00D);

        // Directed cases from the test plan.
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h20, 32'd7, 32'd5, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h22, 32'h1234, 32'h1234, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h2A, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd0, 6'h00, 32'h10, 32'h4, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, 3'd0, 6'h00, 32'h10, 32'h4, 1'b0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h27, 32'd0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd1, 6'h00, 32'd9, 32'd3, 1'b1, 32'h1111_2222);
        applyStimulus(1'b1, 1'b1, 3'd6, 6'h00, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd7, 6'h20, 32'd5, 32'd5, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd2, 6'h21, 32'd5, 32'd5, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd0, 6'h00, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);

        // Reset mid-stream discards the in-flight operation.
        applyStimulus(1'b1, 1'b1, 3'd4, 6'h00, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 32'h7777_8888);
        applyStimulus(1'b0, 1'b1, 3'd0, 6'h00, 32'd3, 32'd4, 1'b1, 32'h7777_8888);

        // Randomized traffic with bubbles and occasional resets.
        for (int i = 0; i < 400; i++) begin
            op = 3'($urandom_range(0, 7));
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 5)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = {a[31], 31'($urandom)};
                default: b = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
                          op, fn, a, b, 1'($urandom), $urandom);
        end

        @(posedge clk);
        #3;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
